// File: rtl/game_pkg.sv
// Types and constants shared by direction_input and the game Core.
// Includes the LFSR step and seed-substitution helpers.
package game_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam logic [2:0]  DIR_IDLE          = 3'b100;
   localparam logic [15:0] LFSR_MASK         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Galois right-shift step; the mask is applied when the dropped bit is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced.
   function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
      return (s == '0) ? LFSR_DEFAULT_SEED : s;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer for one active-low push-button.
// o_stable is the debounced level (1 = pressed); o_rise pulses once per accepted press.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_stable,
   output logic o_rise
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Input is inverted ahead of the synchroniser so the cleared reset state reads as released.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= ~i_key_n;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_rise   <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = r_rise;

endmodule

// File: rtl/direction_input.sv
// Button front-end for Core: debounced one-shot direction and game-reset commands,
// plus a free-running 2-bit pseudo-random direction.
module direction_input
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_key,
   input  logic       i_key_reset,
   output logic [2:0] user_direction,
   output logic       reset,
   output logic [1:0] random_direction
);

   localparam logic [15:0] SEED_EFF = lfsr_seed(LFSR_SEED);

   logic [4:0]  w_key_n;
   logic [4:0]  w_stable;
   logic [4:0]  w_rise;
   logic [3:0]  w_others;
   logic        w_dir_valid;
   dir_t        w_dir;
   logic [15:0] w_lfsr_next;

   logic [3:0]  r_stable_prev;
   logic [2:0]  r_user_direction;
   logic        r_reset;
   logic [15:0] r_lfsr;
   logic [1:0]  r_random_direction;

   assign w_key_n = {i_key_reset, i_key};

   for (genvar g = 0; g < 5; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_key_n (w_key_n[g]),
         .o_stable(w_stable[g]),
         .o_rise  (w_rise[g])
      );
   end

   // A rise is rejected if any other direction key was already held; lowest index wins ties.
   always_comb begin
      w_others    = '0;
      w_dir_valid = 1'b0;
      w_dir       = DIR_UP;
      for (int unsigned k = 0; k < 4; k++) begin
         w_others[k] = |(r_stable_prev & ~(4'b0001 << k));
         if (w_rise[k] && !w_others[k] && !w_dir_valid) begin
            w_dir_valid = 1'b1;
            w_dir       = dir_t'(k[1:0]);
         end
      end
   end

   assign w_lfsr_next = lfsr_next(r_lfsr);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_stable_prev      <= '0;
         r_user_direction   <= DIR_IDLE;
         r_reset            <= 1'b0;
         r_lfsr             <= SEED_EFF;
         r_random_direction <= SEED_EFF[1:0];
      end else begin
         r_stable_prev      <= w_stable[3:0];
         r_user_direction   <= w_dir_valid ? {1'b0, w_dir} : DIR_IDLE;
         r_reset            <= w_rise[4] & w_stable[4];
         r_lfsr             <= w_lfsr_next;
         r_random_direction <= w_lfsr_next[1:0];
      end
   end

   assign user_direction   = r_user_direction;
   assign reset            = r_reset;
   assign random_direction = r_random_direction;

endmodule
